// File: rtl/if_fetch_unit.sv
// Instruction fetch unit: issues word fetches to instruction memory and holds
// one fetched word in a buffer that feeds the IF/ID register. A redirect from
// ID flushes the buffer and restarts fetching at the branch target. Any fetch
// still in flight at that point is allowed to complete and its data is dropped.
//
// state   | meaning
// --------+-------------------------------------------------------------------
// ISSUE   | may start a request at pc_q this cycle (if the buffer can take it)
// WAIT    | request outstanding, address held, data will be captured on ack
// DISCARD | request outstanding after a redirect, data dropped on ack
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clock__i,
    input  logic        reset_n__i,
    input  logic        hazard__i,
    input  logic        branch_taken__i,
    input  logic [31:0] branch_target__i,
    output logic        imem_req__o,
    output logic [31:0] imem_addr__o,
    input  logic        imem_ack__i,
    input  logic [31:0] imem_data__i,
    output logic [31:0] instr__o,
    output logic [31:0] PC_4__o,
    output logic        flush__o
);

    localparam logic [1:0] ST_ISSUE   = 2'd0;
    localparam logic [1:0] ST_WAIT    = 2'd1;
    localparam logic [1:0] ST_DISCARD = 2'd2;

    logic [1:0]  state_q;
    logic [1:0]  state_d;
    logic [31:0] pc_q;
    logic [31:0] hold_addr_q;
    logic        buf_valid_q;
    logic [31:0] buf_instr_q;
    logic [31:0] buf_pc_q;

    logic        consume;
    logic        issue_ok;
    logic        ack_eff;
    logic        capture;

    // Request generation, buffer presentation and capture/consume decisions.
    // A request from ISSUE is only made when the buffer will be free at the
    // edge, so a capture never lands on an unconsumed word. Outputs are held
    // quiet while reset is asserted.
    always_comb begin
        consume  = buf_valid_q & ~hazard__i & ~branch_taken__i;
        issue_ok = ~buf_valid_q | (~hazard__i & ~branch_taken__i);

        imem_req__o  = 1'b0;
        imem_addr__o = pc_q;
        case (state_q)
            ST_ISSUE: begin
                imem_req__o  = issue_ok & reset_n__i;
                imem_addr__o = pc_q;
            end
            ST_WAIT, ST_DISCARD: begin
                imem_req__o  = reset_n__i;
                imem_addr__o = hold_addr_q;
            end
            default: begin
                imem_req__o  = 1'b0;
                imem_addr__o = pc_q;
            end
        endcase

        ack_eff  = imem_ack__i & imem_req__o;
        capture  = ack_eff & ~branch_taken__i & (state_q != ST_DISCARD);
        flush__o = branch_taken__i & reset_n__i;

        instr__o = buf_valid_q ? buf_instr_q : 32'h0;
        PC_4__o  = buf_valid_q ? (buf_pc_q + 32'd4) : 32'h0;
    end

    // Next-state logic; a redirect overrides the normal transitions. An
    // outstanding request that is not acked alongside the redirect still has
    // to be waited out, so it moves to DISCARD.
    always_comb begin
        state_d = state_q;
        if (branch_taken__i) begin
            if (ack_eff) begin
                state_d = ST_ISSUE;
            end else if (imem_req__o) begin
                state_d = ST_DISCARD;
            end else begin
                state_d = ST_ISSUE;
            end
        end else begin
            case (state_q)
                ST_ISSUE:   if (imem_req__o && !ack_eff) state_d = ST_WAIT;
                ST_WAIT:    if (ack_eff) state_d = ST_ISSUE;
                ST_DISCARD: if (ack_eff) state_d = ST_ISSUE;
                default:    state_d = ST_ISSUE;
            endcase
        end
    end

    // State, PC and buffer registers.
    always_ff @(posedge clock__i or negedge reset_n__i) begin
        if (!reset_n__i) begin
            state_q     <= ST_ISSUE;
            pc_q        <= RESET_PC;
            hold_addr_q <= RESET_PC;
            buf_valid_q <= 1'b0;
            buf_instr_q <= 32'h0;
            buf_pc_q    <= 32'h0;
        end else begin
            state_q <= state_d;

            // The address must stay stable for as long as the request is open,
            // even if pc_q is redirected meanwhile.
            if (state_q == ST_ISSUE && imem_req__o && !ack_eff) begin
                hold_addr_q <= pc_q;
            end

            if (branch_taken__i) begin
                buf_valid_q <= 1'b0;
                pc_q        <= branch_target__i & 32'hFFFF_FFFC;
            end else if (capture) begin
                buf_instr_q <= imem_data__i;
                buf_pc_q    <= imem_addr__o;
                buf_valid_q <= 1'b1;
                pc_q        <= imem_addr__o + 32'd4;
            end else if (consume) begin
                buf_valid_q <= 1'b0;
            end
        end
    end

endmodule
